// File: rtl/instruction_fetch_sequencer.sv
// instruction_fetch_sequencer
//   Reads one 16-bit instruction as two little-endian bytes from a byte-wide
//   memory and drives the instruction register byte-load interface (IR_LH,
//   IR_Write, IR_I). Owns the program counter, which steps once per byte.
//   Optional feature macro: FETCH_TIMEOUT_EN adds a memory-ack timeout that
//   aborts the fetch through an ERR state and pulses fetch_err.
//   All outputs are decoded from registered state; there is no input-to-output path.
module instruction_fetch_sequencer #(
   parameter int                ADDR_W         = 16,
   parameter logic [ADDR_W-1:0] RESET_PC       = '0,
   parameter int                TIMEOUT_CYCLES = 8
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              fetch_start,
   input  logic              pc_load,
   input  logic [ADDR_W-1:0] pc_in,
   input  logic              mem_ack,
   input  logic [7:0]        mem_rdata,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              IR_LH,
   output logic              IR_Write,
   output logic [7:0]        IR_I,
   output logic [ADDR_W-1:0] pc_out,
   output logic              busy,
   output logic              fetch_done,
   output logic              fetch_err
);

`ifdef FETCH_TIMEOUT_EN
   typedef enum logic [2:0] {
      S_IDLE, S_REQ_LO, S_WR_LO, S_REQ_HI, S_WR_HI, S_DONE, S_ERR
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_REQ_LO, S_WR_LO, S_REQ_HI, S_WR_HI, S_DONE
   } state_t;
`endif

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_pc;
   logic [7:0]        r_byte;
   logic              w_in_req;

   assign w_in_req = (r_state == S_REQ_LO) || (r_state == S_REQ_HI);

`ifdef FETCH_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] r_tmo;
   logic             w_tmo_hit;

   // The last permitted wait cycle: no ack now means the budget is spent.
   assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));

   // Wait counter: held at zero outside request states, so every request starts fresh.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_tmo <= '0;
      end else if (!w_in_req) begin
         r_tmo <= '0;
      end else if (!mem_ack) begin
         r_tmo <= r_tmo + 1'b1;
      end
   end
`else
   // Timeout depth has no meaning without the timeout logic.
   logic w_unused_cfg;
   assign w_unused_cfg = (TIMEOUT_CYCLES != 0);
`endif

   // State register.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state selection and Moore output decode.
   always_comb begin
      w_next     = r_state;
      mem_req    = 1'b0;
      IR_Write   = 1'b0;
      IR_LH      = 1'b0;
      IR_I       = 8'h00;
      fetch_done = 1'b0;
      fetch_err  = 1'b0;
      case (r_state)
         S_IDLE: begin
            // A PC load takes priority; the fetch request is dropped that cycle.
            if (!pc_load && fetch_start) w_next = S_REQ_LO;
         end
         S_REQ_LO: begin
            mem_req = 1'b1;
            if (mem_ack) w_next = S_WR_LO;
`ifdef FETCH_TIMEOUT_EN
            else if (w_tmo_hit) w_next = S_ERR;
`endif
         end
         S_WR_LO: begin
            IR_Write = 1'b1;
            IR_I     = r_byte;
            w_next   = S_REQ_HI;
         end
         S_REQ_HI: begin
            mem_req = 1'b1;
            if (mem_ack) w_next = S_WR_HI;
`ifdef FETCH_TIMEOUT_EN
            else if (w_tmo_hit) w_next = S_ERR;
`endif
         end
         S_WR_HI: begin
            IR_Write = 1'b1;
            IR_LH    = 1'b1;
            IR_I     = r_byte;
            w_next   = S_DONE;
         end
         S_DONE: begin
            fetch_done = 1'b1;
            w_next     = fetch_start ? S_REQ_LO : S_IDLE;
         end
`ifdef FETCH_TIMEOUT_EN
         S_ERR: begin
            fetch_err = 1'b1;
            w_next    = S_IDLE;
         end
`endif
         default: w_next = S_IDLE;
      endcase
   end

   // PC and byte capture: PC loads only when idle; each accepted byte advances PC (wraps).
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_pc   <= RESET_PC;
         r_byte <= 8'h00;
      end else if ((r_state == S_IDLE) && pc_load) begin
         r_pc <= pc_in;
      end else if (w_in_req && mem_ack) begin
         r_byte <= mem_rdata;
         r_pc   <= r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
   end

   assign mem_addr = r_pc;
   assign pc_out   = r_pc;
   assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Testbench for instruction_fetch_sequencer: random fetch traffic against a
// memory responder with random ack latency; expected IR writes, done pulses,
// request addresses and error pulses are queued by the stimulus and checked
// by independent monitor processes.
`timescale 1ns/1ps
module tb_instruction_fetch_sequencer;
   localparam logic [15:0] RESET_PC = 16'h0000;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic        fetch_start = 1'b0;
   logic        pc_load = 1'b0;
   logic [15:0] pc_in = 16'h0000;
   logic        mem_ack = 1'b0;
   logic [7:0]  mem_rdata = 8'h00;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        IR_LH;
   logic        IR_Write;
   logic [7:0]  IR_I;
   logic [15:0] pc_out;
   logic        busy;
   logic        fetch_done;
   logic        fetch_err;

   instruction_fetch_sequencer #(
      .ADDR_W(16), .RESET_PC(RESET_PC), .TIMEOUT_CYCLES(8)
   ) dut (
      .Clock(Clock), .Reset(Reset), .fetch_start(fetch_start), .pc_load(pc_load),
      .pc_in(pc_in), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_req(mem_req),
      .mem_addr(mem_addr), .IR_LH(IR_LH), .IR_Write(IR_Write), .IR_I(IR_I),
      .pc_out(pc_out), .busy(busy), .fetch_done(fetch_done), .fetch_err(fetch_err)
   );

   always #5 Clock = ~Clock;

   typedef struct { logic lh; logic [7:0] data; } wr_t;
   typedef struct { logic [15:0] pc; int cyc; } done_t;
   typedef struct { logic [15:0] addr; int delay; } req_t;

   wr_t   wr_q[$];
   done_t done_q[$];
   req_t  req_q[$];
   int    err_q[$];

   logic [7:0]  mem [0:65535];
   int          cyc = 0;
   int          n_tests = 0;
   int          n_fail = 0;
   logic [15:0] model_pc;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic void expect_nonempty(input string name, input int size);
      n_tests++;
      if (size == 0) begin
         n_fail++;
         $display("FAIL %s: DUT produced an event with nothing expected (cycle %0d)", name, cyc);
      end
   endfunction

   always @(posedge Clock) cyc <= cyc + 1;

   // Memory responder: acknowledges each request after the delay the stimulus chose.
   logic in_req = 1'b0;
   int   req_cnt = 0;
   req_t cur;
   always @(posedge Clock) begin
      #1;
      if (Reset) begin
         in_req  = 1'b0;
         mem_ack = 1'b0;
      end else if (mem_req) begin
         if (!in_req) begin
            in_req  = 1'b1;
            req_cnt = 0;
            expect_nonempty("mem_req", req_q.size());
            if (req_q.size() != 0) cur = req_q.pop_front();
            else cur = '{addr: mem_addr, delay: 0};
         end
         chk("mem_addr", mem_addr, cur.addr);
         if (req_cnt == cur.delay) begin
            mem_ack   = 1'b1;
            mem_rdata = mem[cur.addr];
            in_req    = 1'b0;
         end else begin
            mem_ack   = 1'b0;
            mem_rdata = 8'($urandom);
            req_cnt++;
         end
      end else begin
         in_req    = 1'b0;
         mem_ack   = 1'($urandom_range(0, 1));
         mem_rdata = 8'($urandom);
      end
   end

   // Output monitor: pops expectations whenever the DUT presents a write, done or error.
   logic  prev_wr = 1'b0;
   wr_t   ew;
   done_t ed;
   always @(negedge Clock) begin
      if (Reset) begin
         prev_wr = 1'b0;
      end else begin
         if (IR_Write) begin
            chk("ir_write_gap", prev_wr, 0);
            expect_nonempty("ir_write", wr_q.size());
            if (wr_q.size() != 0) begin
               ew = wr_q.pop_front();
               $display("[TB] cycle %0d IR write LH=%0d I=0x%02h", cyc, IR_LH, IR_I);
               chk("IR_LH", IR_LH, ew.lh);
               chk("IR_I", IR_I, ew.data);
            end
         end else begin
            chk("IR_LH_idle", IR_LH, 0);
         end
         prev_wr = IR_Write;
         if (fetch_done) begin
            expect_nonempty("fetch_done", done_q.size());
            if (done_q.size() != 0) begin
               ed = done_q.pop_front();
               $display("[TB] cycle %0d fetch_done pc_out=0x%04h", cyc, pc_out);
               chk("done_pc", pc_out, ed.pc);
               chk("done_cycle", cyc, ed.cyc);
               chk("done_busy", busy, 1);
            end
         end
         if (fetch_err) begin
            expect_nonempty("fetch_err", err_q.size());
            if (err_q.size() != 0) chk("err_cycle", cyc, err_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   // Load PC while idle; fetch_start may be high too and must lose that cycle.
   task automatic load_pc(input logic [15:0] p);
      pc_load     = 1'b1;
      pc_in       = p;
      fetch_start = 1'($urandom_range(0, 1));
      tick();
      pc_load     = 1'b0;
      fetch_start = 1'b0;
      model_pc    = p;
   endtask

   // n back-to-back fetches with fetch_start held high; expectations from the model PC.
   task automatic fetch_burst(input int n, input int dlo, input int dhi, input bit rnd);
      int start_c, done_c, a, b;
      fetch_start = 1'b1;
      start_c = cyc;
      for (int k = 0; k < n; k++) begin
         a = rnd ? int'($urandom_range(0, 3)) : dlo;
         b = rnd ? int'($urandom_range(0, 3)) : dhi;
         req_q.push_back('{addr: model_pc, delay: a});
         wr_q.push_back('{lh: 1'b0, data: mem[model_pc]});
         req_q.push_back('{addr: model_pc + 16'd1, delay: b});
         wr_q.push_back('{lh: 1'b1, data: mem[model_pc + 16'd1]});
         model_pc = model_pc + 16'd2;
         done_c = start_c + 5 + a + b;
         done_q.push_back('{pc: model_pc, cyc: done_c});
         tick();
         if (k == n - 1) fetch_start = 1'b0;
         while (cyc < done_c) begin
            pc_load = 1'($urandom_range(0, 1));
            pc_in   = 16'($urandom);
            tick();
         end
         pc_load = 1'($urandom_range(0, 1));
         pc_in   = 16'($urandom);
         start_c = done_c;
      end
      tick();
      pc_load = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int start_c;
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      mem[16'h0100] = 8'h34;
      mem[16'h0101] = 8'h12;
      model_pc = RESET_PC;

      // Reset values
      tick();
      tick();
      chk("rst_mem_req", mem_req, 0);
      chk("rst_IR_Write", IR_Write, 0);
      chk("rst_IR_LH", IR_LH, 0);
      chk("rst_IR_I", IR_I, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fetch_done", fetch_done, 0);
      chk("rst_fetch_err", fetch_err, 0);
      chk("rst_pc_out", pc_out, RESET_PC);
      chk("rst_mem_addr", mem_addr, RESET_PC);
      Reset = 1'b0;
      tick();

      // Same-cycle ack, then 3-cycle ack delay per byte, then a 3-fetch burst
      load_pc(16'h0100);
      fetch_burst(1, 0, 0, 1'b0);
      load_pc(16'h0100);
      fetch_burst(1, 3, 3, 1'b0);
      fetch_burst(3, 0, 0, 1'b0);

      // PC wrap: high byte comes from 0x0000
      load_pc(16'hFFFF);
      fetch_burst(1, 0, 0, 1'b0);
      chk("wrap_pc", pc_out, 16'h0001);

      // Reset during the high-byte request; pc_load while busy ignored
      load_pc(16'h0200);
      fetch_start = 1'b1;
      start_c = cyc;
      req_q.push_back('{addr: 16'h0200, delay: 0});
      wr_q.push_back('{lh: 1'b0, data: mem[16'h0200]});
      req_q.push_back('{addr: 16'h0201, delay: 20});
      tick();
      fetch_start = 1'b0;
      tick();
      tick();
      pc_load = 1'b1;
      pc_in   = 16'hBEEF;
      tick();
      chk("pc_load_busy", pc_out, 16'h0201);
      chk("busy_in_req_hi", busy, 1);
      pc_load = 1'b0;
      #2;
      Reset = 1'b1;
      #1;
      chk("abort_mem_req", mem_req, 0);
      chk("abort_busy", busy, 0);
      chk("abort_IR_Write", IR_Write, 0);
      chk("abort_pc_out", pc_out, RESET_PC);
      tick();
      tick();
      Reset = 1'b0;
      req_q.delete();
      model_pc = RESET_PC;
      $display("[TB] cycle %0d reset abort from fetch started at cycle %0d", cyc, start_c);
      tick();

`ifdef FETCH_TIMEOUT_EN
      // No ack on the low byte: error pulse after 8 wait cycles, PC unchanged
      load_pc(16'h0300);
      fetch_start = 1'b1;
      start_c = cyc;
      req_q.push_back('{addr: 16'h0300, delay: 1000});
      err_q.push_back(start_c + 9);
      tick();
      fetch_start = 1'b0;
      repeat (10) tick();
      chk("tmo_pc_out", pc_out, 16'h0300);
      chk("tmo_busy", busy, 0);
`endif

      // Random traffic
      for (int t = 0; t < 30; t++) begin
         if ($urandom_range(0, 1) == 1) load_pc(16'($urandom));
         fetch_burst(int'($urandom_range(1, 3)), 0, 0, 1'b1);
         repeat ($urandom_range(0, 2)) tick();
      end

      repeat (4) tick();
      chk("wr_q_drained", wr_q.size(), 0);
      chk("done_q_drained", done_q.size(), 0);
      chk("req_q_drained", req_q.size(), 0);
      chk("err_q_drained", err_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
